// File: rtl/tlc5615_pkg.sv
// Shared types and frame geometry for the TLC5615 serial DAC writer.
package tlc5615_pkg;
  localparam int DATA_BITS  = 10;
  localparam int PAD_BITS   = 2;
  localparam int FRAME_BITS = 12;

  typedef enum logic [1:0] {IDLE, SHIFT, END, GAP} state_t;
endpackage

// File: rtl/tlc5615_tick.sv
// Free-running tick generator: one-cycle pulse every DIVIDER+1 clk cycles.
module tlc5615_tick #(
  parameter int DIVIDER = 24
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIVIDER < 1) ? 1 : $clog2(DIVIDER + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)              r_cnt <= CW'(DIVIDER);
    else if (r_cnt == '0) r_cnt <= CW'(DIVIDER);
    else                  r_cnt <= r_cnt - 1'b1;
  end

  assign tick = (r_cnt == '0);
endmodule

// File: rtl/tlc5615_dac.sv
// TLC5615 3-wire writer: sends {value,2'b00} MSB first after reset and on change.
// Optional periodic re-send of an unchanged value: define TLC5615_REFRESH_EN.
module tlc5615_dac
  import tlc5615_pkg::*;
#(
  parameter int DIVIDER   = 24,
  parameter int GAP_TICKS = 4
`ifdef TLC5615_REFRESH_EN
  ,
  parameter int REFRESH_TICKS = 40000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] value,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs,
  output logic                 busy
);
  logic w_tick;

  tlc5615_tick #(.DIVIDER(DIVIDER)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  state_t                r_state,   w_state;
  logic [FRAME_BITS-1:0] r_shift,   w_shift;
  logic [DATA_BITS-1:0]  r_last,    w_last;
  logic                  r_force,   w_force;
  logic [3:0]            r_bit_cnt, w_bit_cnt;
  logic [7:0]            r_gap_cnt, w_gap_cnt;
  logic                  r_sclk,    w_sclk;
  logic                  r_mosi,    w_mosi;
  logic                  r_cs,      w_cs;
  logic                  r_busy,    w_busy;
  logic                  w_want;

`ifdef TLC5615_REFRESH_EN
  logic [15:0] r_refresh_cnt, w_refresh_cnt;
  logic        w_refresh_due;
  assign w_refresh_due = (r_refresh_cnt == 16'(REFRESH_TICKS - 1));
  assign w_want        = r_force || (value != r_last) || w_refresh_due;
`else
  assign w_want = r_force || (value != r_last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_last    <= '0;
      r_force   <= 1'b1;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_last    <= w_last;
      r_force   <= w_force;
      r_bit_cnt <= w_bit_cnt;
      r_gap_cnt <= w_gap_cnt;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_cs      <= w_cs;
      r_busy    <= w_busy;
    end
  end

`ifdef TLC5615_REFRESH_EN
  always_ff @(posedge clk) begin
    if (rst) r_refresh_cnt <= '0;
    else     r_refresh_cnt <= w_refresh_cnt;
  end
`endif

  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_last    = r_last;
    w_force   = r_force;
    w_bit_cnt = r_bit_cnt;
    w_gap_cnt = r_gap_cnt;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_cs      = r_cs;
    w_busy    = r_busy;
`ifdef TLC5615_REFRESH_EN
    w_refresh_cnt = r_refresh_cnt;
`endif
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (w_want) begin
            w_shift   = {value, {PAD_BITS{1'b0}}};
            w_last    = value;
            w_force   = 1'b0;
            w_cs      = 1'b0;
            w_mosi    = value[DATA_BITS-1];
            w_busy    = 1'b1;
            w_bit_cnt = '0;
            w_sclk    = 1'b0;
            w_state   = SHIFT;
`ifdef TLC5615_REFRESH_EN
            w_refresh_cnt = '0;
          end else begin
            w_refresh_cnt = r_refresh_cnt + 16'd1;
`endif
          end
        end
        SHIFT: begin
          // data only moves on falling ticks so it is stable around each rise
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else begin
            w_sclk = 1'b0;
            if (r_bit_cnt < 4'(FRAME_BITS - 1)) begin
              w_shift   = {r_shift[FRAME_BITS-2:0], 1'b0};
              w_mosi    = r_shift[FRAME_BITS-2];
              w_bit_cnt = r_bit_cnt + 4'd1;
            end else begin
              w_mosi  = 1'b0;
              w_state = END;
            end
          end
        end
        END: begin
          w_cs      = 1'b1;
          w_gap_cnt = '0;
          w_state   = GAP;
        end
        GAP: begin
          if (r_gap_cnt == 8'(GAP_TICKS - 1)) begin
            w_busy  = 1'b0;
            w_state = IDLE;
          end else begin
            w_gap_cnt = r_gap_cnt + 8'd1;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs   = r_cs;
  assign busy = r_busy;
endmodule

// File: tb/tb_tlc5615_dac.sv
// Directed bench for tlc5615_dac: decodes frames off the wire and checks them.
module tb_tlc5615_dac;
  localparam int DIV = 1;
  localparam int GAPT = 2;
  localparam int LOW_CLK = 25 * (DIV + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] value = 10'h2AA;
  logic       sclk, mosi, cs, busy;

  always #5 clk = ~clk;

  tlc5615_dac #(
    .DIVIDER(DIV),
    .GAP_TICKS(GAPT)
`ifdef TLC5615_REFRESH_EN
    ,
    .REFRESH_TICKS(10)
`endif
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .sclk (sclk),
    .mosi (mosi),
    .cs   (cs),
    .busy (busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          low_clk;
  } frame_t;

  frame_t      fq[$];
  logic [11:0] m_bits = '0;
  int          m_n = 0;
  int          m_low = 0;
  int          m_high = 0;
  int          last_gap = 0;
  logic        seen_rise = 1'b0;
  logic        p_sclk = 1'b0;
  logic        p_cs = 1'b1;

  // wire-level decoder: bit captured at every sclk rise while cs is low
  initial forever begin
    @(negedge clk);
    if (!cs && p_cs) begin
      m_bits = '0;
      m_n    = 0;
      m_low  = 0;
      if (seen_rise) last_gap = m_high;
    end
    if (!cs) m_low++;
    if (!cs && sclk && !p_sclk) begin
      m_bits = {m_bits[10:0], mosi};
      m_n++;
    end
    if (cs && !p_cs) begin
      fq.push_back('{m_bits, m_n, m_low});
      m_high    = 0;
      seen_rise = 1'b1;
    end
    if (cs) m_high++;
    p_sclk = sclk;
    p_cs   = cs;
  end

  task automatic wait_frame(input string name, output frame_t f);
    bit got = 1'b0;
    f = '{12'h0, 0, 0};
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      #1;
      if (fq.size() > 0) begin
        f   = fq.pop_front();
        got = 1'b1;
      end
    end
    if (!got) chk({name, " frame timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [9:0]  v;
    logic [11:0] bits;
  } vec_t;

  vec_t   vecs[5];
  frame_t f;

  initial begin
    vecs[0] = '{10'h2AA, 12'hAA8};
    vecs[1] = '{10'h3FF, 12'hFFC};
    vecs[2] = '{10'h000, 12'h000};
    vecs[3] = '{10'h201, 12'h804};
    vecs[4] = '{10'h155, 12'h554};

    repeat (3) @(posedge clk);
    #1;
    chk("rst cs", int'(cs), 1);
    chk("rst sclk", int'(sclk), 0);
    chk("rst mosi", int'(mosi), 0);
    chk("rst busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      value = vecs[i].v;
      wait_frame("vec", f);
      chk($sformatf("vec%0d bits", i), int'(f.bits), int'(vecs[i].bits));
      chk($sformatf("vec%0d nbits", i), f.nbits, 12);
      chk($sformatf("vec%0d cs_low", i), f.low_clk, LOW_CLK);
      if (i >= 2) chk($sformatf("vec%0d gap", i), last_gap, 2 * (GAPT + 1));
      if (i == 0) begin
        repeat (20) @(negedge clk);
        chk("idle busy", int'(busy), 0);
`ifndef TLC5615_REFRESH_EN
        chk("no repeat frame", fq.size(), 0);
`endif
      end
    end

    // in-flight frame keeps 001; only the newest pending value follows
    value = 10'h001;
    for (int c = 0; c < 100 && cs; c++) @(negedge clk);
    chk("mc cs fell", int'(cs), 0);
    repeat (4) @(negedge clk);
    value = 10'h155;
    repeat (4) @(negedge clk);
    value = 10'h0F0;
    wait_frame("mc1", f);
    chk("mc first bits", int'(f.bits), 12'h004);
    wait_frame("mc2", f);
    chk("mc second bits", int'(f.bits), 12'h3C0);
    chk("mc gap", last_gap, 2 * (GAPT + 1));
    repeat (60) @(negedge clk);
`ifndef TLC5615_REFRESH_EN
    chk("mc 155 dropped", fq.size(), 0);
`endif

    // reset at the 6th sclk rise truncates the frame; a full one follows
    fq.delete();
    value = 10'h2AA;
    for (int c = 0; c < 200 && m_n != 6; c++) begin
      @(negedge clk);
      #1;
    end
    chk("mid rst reached bit6", m_n, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst cs", int'(cs), 1);
    chk("mid rst sclk", int'(sclk), 0);
    chk("mid rst busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_frame("trunc", f);
    chk("trunc nbits", f.nbits, 6);
    chk("trunc bits", int'(f.bits[5:0]), 6'h2A);
    wait_frame("post rst", f);
    chk("post rst bits", int'(f.bits), 12'hAA8);
    chk("post rst nbits", f.nbits, 12);

`ifdef TLC5615_REFRESH_EN
    wait_frame("refresh", f);
    chk("refresh bits", int'(f.bits), 12'hAA8);
    chk("refresh gap", last_gap, 2 * (GAPT + 10));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tlc5615_dac.md
Name: tlc5615_dac

Overview:
Serial writer for a TI TLC5615 10-bit DAC. It is the transmit-side counterpart of the team's TLC549 ADC reader. The block takes a parallel 10-bit setpoint from the host register file and shifts it out as a 12-bit 3-wire frame: CS, SCLK, DIN, MSB first, two trailing zero bits. A frame is sent after reset and whenever the setpoint changes. The DAC output updates on the rising edge of CS.

Parameters:
DIVIDER, 24, clk cycles per half SCLK period minus 1; tick period = DIVIDER+1 clk cycles.
GAP_TICKS, 4, minimum ticks CS stays high between frames; range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
value  input  10  DAC setpoint, unsigned; sampled only at frame start
sclk  output  1  serial clock to DAC
mosi  output  1  serial data to DAC (DIN)
cs  output  1  chip select, active-low
busy  output  1  high while a frame or inter-frame gap is in progress

Behaviour:
- Reset (rst=1 at posedge clk): cs=1, sclk=0, mosi=0, busy=0, state=IDLE, tick counter=DIVIDER, bit counter=0, force flag=1, last_sent=0.
- Tick generator: the down-counter decrements each clk. When it is 0 it asserts tick for one clk and reloads DIVIDER. All FSM transitions occur only on tick cycles.
- IDLE: cs=1, sclk=0, busy=0.
  - On tick, if force=1 or value!=last_sent:
    - shift_reg={value,2'b00}, last_sent=value, force=0.
    - cs<=0, mosi<=value[9], busy<=1, bit counter=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each tick toggles sclk.
  - Rising tick (sclk 0->1): no data change; the DAC samples here.
  - Falling tick (sclk 1->0), bit counter<11: shift shift_reg left, mosi<=next bit, bit counter++.
  - Falling tick, bit counter==11: mosi<=0, go to END.
  - Result: 12 rising edges per frame; mosi is stable a full half-period before and after each rising edge.
- END: on the next tick, cs<=1 (DAC latch), sclk stays 0, go to GAP.
- GAP: count GAP_TICKS ticks with cs=1, busy=1, then go to IDLE with busy<=0.
- Frame timing with tick index 0 = CS fall:
  - rising edges at ticks 1,3,...,23; falling edges at 2,...,24; CS rise at tick 25.
  - cs is low for exactly 25*(DIVIDER+1) clk cycles.
- A change on value during SHIFT/END/GAP does not affect the frame in flight; it is picked up on the first IDLE tick after GAP. Only the latest value is sent; intermediate values are dropped.
- value returning to last_sent before IDLE produces no new frame.
- rst mid-frame: outputs return to reset values on the same edge (cs rises, truncated frame is discarded by the DAC); force=1 makes a full frame go out after reset.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
TLC5615_REFRESH_EN.
- Defined: a 16-bit refresh counter, parameter REFRESH_TICKS default 40000, counts ticks in IDLE. When it expires it sets force=1, so the current value is re-sent periodically even if unchanged. The counter clears whenever a frame starts.
- Not defined: frames are sent only on reset and on change; the counter logic and REFRESH_TICKS are absent.

Decomposition:
- Package tlc5615_pkg holds:
  - state enum {IDLE, SHIFT, END, GAP}
  - DATA_BITS=10, FRAME_BITS=12, PAD_BITS=2
- One sub-module, tlc5615_tick: parameter DIVIDER, ports clk/rst/tick; the shared tick generator.
- FSM and shift register stay in the top module.

Test Plan:
- DIVIDER=1, GAP_TICKS=2, value=10'h2AA held from reset -> one frame; mosi at the 12 sclk rises = 1010101010 00; cs low for 50 clk; busy then drops; no second frame.
- After IDLE, step value to 10'h3FF -> frame starts on the next tick; bits 1111111111 00; last_sent=3FF.
- Change value 10'h001 -> 10'h155 -> 10'h0F0 within one frame -> the in-flight frame carries 001; exactly one following frame carries 0F0; 155 is never sent.
- Assert rst at the 6th sclk rise of a frame -> same edge gives cs=1, sclk=0, busy=0; after release a full frame of the current value follows.
- Change value during GAP -> CS-high time between frames is >= GAP_TICKS+1 ticks (6 clk with DIVIDER=1).
- With TLC5615_REFRESH_EN and REFRESH_TICKS=10, value held constant -> frames repeat, each starting 10 ticks after the previous return to IDLE.
